minibyte_regfile: RTL and testbench
===================================

Name: minibyte_regfile

Overview:
- Parametrised successor to the 4-byte register RAM: 2**ADDR_W entries of DATA_W bits.
- One synchronous write port and two independent synchronous read ports (A, B), each read with 1-cycle latency.
- Write-to-read bypass on both read ports.
- Hardware bulk-clear sequencer that zeroes every entry, one per cycle.
- Serves as the general-purpose register file for the minibyte CPU datapath: ALU operand fetch on A/B, writeback on the write port.

Parameters:
- DATA_W, 8, width of each entry in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- en_in  input  1  block enable; when low, no reads or writes are accepted.
- we_in  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- rd_data_a  output  DATA_W  registered read data, port A.
- rd_valid_a  output  1  rd_data_a updated this cycle.
- rd_en_b  input  1  read request, port B.
- rd_addr_b  input  ADDR_W  read address, port B.
- rd_data_b  output  DATA_W  registered read data, port B.
- rd_valid_b  output  1  rd_data_b updated this cycle.
- clr_in  input  1  start bulk clear (single-cycle pulse or level).
- busy_out  output  1  bulk clear in progress.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - All DEPTH entries go to 0.
  - rd_data_a/b = 0, rd_valid_a/b = 0, busy_out = 0.
  - FSM goes to IDLE and the clear pointer goes to 0.
  - Reset has priority over every other input, including mid-clear; a clear in progress is aborted, which is harmless because reset zeroes all entries anyway.
- Outputs are always driven; there is no tri-state.
- Write:
  - Condition: en_in=1, we_in=1, FSM in IDLE.
  - Effect: mem[wr_addr] <= wr_data at the edge.
  - Writes are ignored while busy_out=1.
- Read, per port independently:
  - Condition: en_in=1 and rd_en_x=1.
  - At the next edge, rd_data_x <= the selected value and rd_valid_x <= 1.
  - Otherwise rd_valid_x <= 0 and rd_data_x holds its previous value.
  - Reads are permitted while busy.
- Bypass (write-first):
  - If an accepted write targets rd_addr_x in the same cycle, rd_data_x gets wr_data.
  - During CLEAR, a read whose address equals the clear pointer returns 0.
- A and B may read the same address in the same cycle; both return identical data.
- en_in=0: no memory update, rd_valid_a/b <= 0, rd_data held. The clear FSM still advances; en_in gates only port accesses.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_in=1. The pointer loads 0; busy_out is 1 from the next cycle.
  - While in CLEAR, each cycle sets mem[ptr] <= 0 and ptr <= ptr+1.
  - When ptr = DEPTH-1, that entry is cleared and the FSM returns to IDLE. busy_out is 0 in the following cycle.
  - busy_out is high for exactly DEPTH cycles.
  - clr_in while in CLEAR is ignored; it does not restart the sequence.
  - A clr_in and we_in in the same IDLE cycle: the write is performed and the clear then starts, so the written entry is cleared later.
- Pointer width is ADDR_W. It wraps naturally, but the FSM exits before any wrap is observable.
- Latency:
  - Read: 1 cycle from request to data.
  - Write: visible to a read issued the same cycle through the bypass, and to any later read from storage.

Test Plan:
- Reset then read all addresses on A and B (DATA_W=8, ADDR_W=2) -> every read returns 0x00 with rd_valid=1 one cycle after each request.
- Write 0xA5 to addr 2, then read addr 2 on A and addr 0 on B next cycle -> rd_data_a=0xA5, rd_data_b=0x00, both valid one cycle later.
- Same cycle: write 0x3C to addr 1 and read addr 1 on both ports -> next cycle rd_data_a=rd_data_b=0x3C (bypass).
- Fill entries with 0x11/0x22/0x33/0x44, pulse clr_in, and attempt a write of 0xFF to addr 3 while busy:
  - busy_out high for exactly 4 cycles.
  - A read of addr 3 during the clear returns 0x44 before the pointer reaches it and 0x00 after.
  - Final contents are all 0x00; the 0xFF write is dropped.
- en_in=0 with we_in=1, rd_en_a=1 -> no write occurs, rd_valid_a=0, rd_data_a holds its prior value.
- Assert rst_in two cycles into a clear with entries pre-loaded -> next cycle busy_out=0, all entries 0, rd_valid=0; a new clr_in afterwards runs the full DEPTH cycles.

Source files
------------

// File: rtl/minibyte_regfile_if.sv
// Port bundle for minibyte_regfile: write port, two read ports and bulk-clear control.
interface minibyte_regfile_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              en_in;
    logic              we_in;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              clr_in;
    logic              busy_out;

    modport master (
        output en_in, we_in, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_in,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy_out
    );

    modport slave (
        input  en_in, we_in, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_in,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, busy_out
    );
endinterface

// File: rtl/minibyte_regfile.sv
// 1W/2R register file with write-first bypass and a one-entry-per-cycle bulk-clear sequencer.
module minibyte_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input logic               clk_in,
    input logic               rst_in,
    minibyte_regfile_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_accept;
    logic              clearing;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign clearing  = (state == CLEAR);
    assign wr_accept = bus.en_in && bus.we_in && !clearing;

    // Read selection: same-cycle write wins, then the entry being cleared reads as zero.
    always_comb begin
        sel_a = mem[bus.rd_addr_a];
        sel_b = mem[bus.rd_addr_b];
        if (wr_accept && (bus.wr_addr == bus.rd_addr_a)) begin
            sel_a = bus.wr_data;
        end else if (clearing && (ptr == bus.rd_addr_a)) begin
            sel_a = '0;
        end
        if (wr_accept && (bus.wr_addr == bus.rd_addr_b)) begin
            sel_b = bus.wr_data;
        end else if (clearing && (ptr == bus.rd_addr_b)) begin
            sel_b = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem            <= '{default: '0};
            state          <= IDLE;
            ptr            <= '0;
            bus.busy_out   <= 1'b0;
            bus.rd_data_a  <= '0;
            bus.rd_valid_a <= 1'b0;
            bus.rd_data_b  <= '0;
            bus.rd_valid_b <= 1'b0;
        end else begin
            bus.rd_valid_a <= bus.en_in && bus.rd_en_a;
            bus.rd_valid_b <= bus.en_in && bus.rd_en_b;
            if (bus.en_in && bus.rd_en_a) begin
                bus.rd_data_a <= sel_a;
            end
            if (bus.en_in && bus.rd_en_b) begin
                bus.rd_data_b <= sel_b;
            end

            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        mem[bus.wr_addr] <= bus.wr_data;
                    end
                    // A write in the same cycle lands first; the sweep clears it later.
                    if (bus.clr_in) begin
                        state        <= CLEAR;
                        ptr          <= '0;
                        bus.busy_out <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + ADDR_W'(1);
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state        <= IDLE;
                        bus.busy_out <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_minibyte_regfile.sv
// Directed testbench for minibyte_regfile (DATA_W=8, ADDR_W=2).
module tb_minibyte_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   busy_cnt;

    minibyte_regfile_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    minibyte_regfile #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        bus.we_in   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.we_in   = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] a, input logic [1:0] b);
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = a;
        bus.rd_en_b   = 1'b1;
        bus.rd_addr_b = b;
        tick();
        bus.rd_en_a   = 1'b0;
        bus.rd_en_b   = 1'b0;
    endtask

    initial begin
        bus.en_in     = 1'b1;
        bus.we_in     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_en_a   = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_en_b   = 1'b0;
        bus.rd_addr_b = '0;
        bus.clr_in    = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid_a", 32'(bus.rd_valid_a), 32'd0);
        chk("rst_valid_b", 32'(bus.rd_valid_b), 32'd0);
        chk("rst_data_a", 32'(bus.rd_data_a), 32'h00);
        chk("rst_data_b", 32'(bus.rd_data_b), 32'h00);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);

        // All entries read zero after reset, on both ports
        for (int i = 0; i < 4; i++) begin
            rd2(2'(i), 2'(3 - i));
            chk("init_a", 32'(bus.rd_data_a), 32'h00);
            chk("init_b", 32'(bus.rd_data_b), 32'h00);
            chk("init_va", 32'(bus.rd_valid_a), 32'd1);
            chk("init_vb", 32'(bus.rd_valid_b), 32'd1);
        end
        tick();
        chk("idle_va", 32'(bus.rd_valid_a), 32'd0);

        // Write then read from storage
        wr(2'd2, 8'hA5);
        rd2(2'd2, 2'd0);
        chk("wr_rd_a", 32'(bus.rd_data_a), 32'hA5);
        chk("wr_rd_b", 32'(bus.rd_data_b), 32'h00);
        chk("wr_rd_va", 32'(bus.rd_valid_a), 32'd1);

        // Same-cycle bypass on both ports
        bus.we_in   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 8'h3C;
        rd2(2'd1, 2'd1);
        bus.we_in   = 1'b0;
        chk("byp_a", 32'(bus.rd_data_a), 32'h3C);
        chk("byp_b", 32'(bus.rd_data_b), 32'h3C);

        // Fill, then bulk clear with a dropped write to addr 3
        wr(2'd0, 8'h11);
        wr(2'd1, 8'h22);
        wr(2'd2, 8'h33);
        wr(2'd3, 8'h44);
        bus.clr_in    = 1'b1;
        bus.rd_en_a   = 1'b1;
        bus.rd_addr_a = 2'd3;
        tick();
        bus.clr_in  = 1'b0;
        chk("clr_busy0", 32'(bus.busy_out), 32'd1);
        chk("clr_rd0", 32'(bus.rd_data_a), 32'h44);
        bus.we_in   = 1'b1;
        bus.wr_addr = 2'd3;
        bus.wr_data = 8'hFF;
        tick();
        chk("clr_busy1", 32'(bus.busy_out), 32'd1);
        chk("clr_rd1", 32'(bus.rd_data_a), 32'h44);
        bus.clr_in = 1'b1;
        tick();
        bus.clr_in = 1'b0;
        chk("clr_busy2", 32'(bus.busy_out), 32'd1);
        chk("clr_rd2", 32'(bus.rd_data_a), 32'h44);
        tick();
        chk("clr_busy3", 32'(bus.busy_out), 32'd1);
        chk("clr_rd3", 32'(bus.rd_data_a), 32'h44);
        tick();
        bus.we_in   = 1'b0;
        bus.rd_en_a = 1'b0;
        chk("clr_busy4", 32'(bus.busy_out), 32'd0);
        chk("clr_rd4", 32'(bus.rd_data_a), 32'h00);
        for (int i = 0; i < 4; i++) begin
            rd2(2'(i), 2'(i));
            chk("clr_final_a", 32'(bus.rd_data_a), 32'h00);
            chk("clr_final_b", 32'(bus.rd_data_b), 32'h00);
        end

        // en_in low blocks the write and the read
        wr(2'd0, 8'h5A);
        rd2(2'd0, 2'd0);
        chk("en_pre", 32'(bus.rd_data_a), 32'h5A);
        bus.en_in = 1'b0;
        bus.we_in = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 8'h77;
        rd2(2'd0, 2'd0);
        bus.we_in = 1'b0;
        bus.en_in = 1'b1;
        chk("en_va", 32'(bus.rd_valid_a), 32'd0);
        chk("en_hold_a", 32'(bus.rd_data_a), 32'h5A);
        rd2(2'd0, 2'd0);
        chk("en_nowr", 32'(bus.rd_data_a), 32'h5A);

        // Reset two cycles into a clear
        wr(2'd0, 8'h01);
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h04);
        bus.clr_in = 1'b1;
        tick();
        bus.clr_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        bus.rd_en_a = 1'b1;
        bus.rd_addr_a = 2'd3;
        tick();
        rst = 1'b0;
        bus.rd_en_a = 1'b0;
        chk("rstclr_busy", 32'(bus.busy_out), 32'd0);
        chk("rstclr_va", 32'(bus.rd_valid_a), 32'd0);
        chk("rstclr_da", 32'(bus.rd_data_a), 32'h00);
        for (int i = 0; i < 4; i++) begin
            rd2(2'(i), 2'(i));
            chk("rstclr_mem", 32'(bus.rd_data_a), 32'h00);
        end

        // Clear with a same-cycle write: write lands, then gets swept
        bus.clr_in  = 1'b1;
        bus.we_in   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 8'h99;
        tick();
        bus.clr_in  = 1'b0;
        bus.we_in   = 1'b0;
        busy_cnt = 32'(bus.busy_out);
        rd2(2'd1, 2'd2);
        chk("clrwr_seen", 32'(bus.rd_data_a), 32'h99);
        busy_cnt += 32'(bus.busy_out);
        for (int i = 0; i < 10 && bus.busy_out; i++) begin
            tick();
            busy_cnt += 32'(bus.busy_out);
        end
        chk("clr_full_len", 32'(busy_cnt), 32'd4);
        chk("clr_done", 32'(bus.busy_out), 32'd0);
        rd2(2'd1, 2'd1);
        chk("clrwr_gone", 32'(bus.rd_data_b), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
